spi_master_arbiter: RTL and testbench

//  Shares one SPI_Master_CS instance between NUM_REQ requesters. Each requester posts a

---
 rtl/spi_master_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI_Master_CS between NUM_REQ requesters.
// Each grant is one CS frame; TX bytes are handed to the master one at a time.
//
// state   | meaning
// IDLE    | no owner, scanning requests from the round-robin pointer
// GRANT   | owner latched, decide between empty and real transfer
// SEND    | waiting for master ready to launch the owner's next byte
// WAIT_RX | one byte in flight, waiting for the master's receive strobe
// DONE    | report completion, release grant, advance pointer
module spi_master_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int MAX_BYTES_PER_CS = 10,
  localparam int CW              = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    i_Req,
  input  logic [NUM_REQ*CW-1:0] i_Req_Count,
  input  logic [NUM_REQ*8-1:0]  i_Req_Byte,
  output logic [NUM_REQ-1:0]    o_Grant,
  output logic [NUM_REQ-1:0]    o_Pop,
  output logic [7:0]            o_RX_Byte,
  output logic [NUM_REQ-1:0]    o_RX_Valid,
  output logic [NUM_REQ-1:0]    o_Done,
  output logic [7:0]            o_M_TX_Byte,
  output logic                  o_M_TX_En,
  input  logic                  i_M_TX_Ready,
  output logic [CW-1:0]         o_M_TX_Count,
  input  logic [7:0]            i_M_RX_Byte,
  input  logic                  i_M_RX_En
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SEND, S_WAIT_RX, S_DONE} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     owner, owner_nx;
  logic [PW-1:0]     rr_ptr, rr_ptr_nx;
  logic [PW-1:0]     pick;
  logic              found;
  logic [CW-1:0]     bytes_left, bytes_left_nx;
  logic [CW-1:0]     cnt_sel, cnt_clamped;
  logic [NUM_REQ-1:0] owner_mask;

  logic [NUM_REQ-1:0] grant_nx, pop_nx, rx_valid_nx, done_nx;
  logic [7:0]         rx_byte_nx, m_tx_byte_nx;
  logic               m_tx_en_nx;
  logic [CW-1:0]      m_tx_count_nx;

  logic [CW-1:0] req_count [NUM_REQ];
  logic [7:0]    req_byte  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_count[g] = i_Req_Count[g*CW +: CW];
    assign req_byte[g]  = i_Req_Byte[g*8 +: 8];
  end

  // First pass covers pointer..top, second pass wraps to the bottom.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && i_Req[j] && (j >= int'(rr_ptr))) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && i_Req[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  always_comb begin
    cnt_sel     = req_count[pick];
    cnt_clamped = (cnt_sel > CW'(MAX_BYTES_PER_CS)) ? CW'(MAX_BYTES_PER_CS) : cnt_sel;
  end

  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    rr_ptr_nx     = rr_ptr;
    bytes_left_nx = bytes_left;
    grant_nx      = o_Grant;
    pop_nx        = '0;
    rx_valid_nx   = '0;
    done_nx       = '0;
    rx_byte_nx    = o_RX_Byte;
    m_tx_byte_nx  = o_M_TX_Byte;
    m_tx_en_nx    = 1'b0;
    m_tx_count_nx = o_M_TX_Count;
    case (state)
      S_IDLE: begin
        if (found) begin
          owner_nx       = pick;
          grant_nx       = '0;
          grant_nx[pick] = 1'b1;
          m_tx_count_nx  = cnt_clamped;
          bytes_left_nx  = cnt_clamped;
          state_nx       = S_GRANT;
        end
      end
      S_GRANT: state_nx = (bytes_left == '0) ? S_DONE : S_SEND;
      S_SEND: begin
        if (i_M_TX_Ready) begin
          m_tx_byte_nx  = req_byte[owner];
          m_tx_en_nx    = 1'b1;
          pop_nx        = owner_mask;
          bytes_left_nx = bytes_left - 1'b1;
          state_nx      = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        if (i_M_RX_En) begin
          rx_byte_nx  = i_M_RX_Byte;
          rx_valid_nx = owner_mask;
          state_nx    = (bytes_left != '0) ? S_SEND : S_DONE;
        end
      end
      S_DONE: begin
        done_nx   = owner_mask;
        grant_nx  = '0;
        rr_ptr_nx = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      bytes_left   <= '0;
      o_Grant      <= '0;
      o_Pop        <= '0;
      o_RX_Byte    <= '0;
      o_RX_Valid   <= '0;
      o_Done       <= '0;
      o_M_TX_Byte  <= '0;
      o_M_TX_En    <= 1'b0;
      o_M_TX_Count <= '0;
    end else begin
      state        <= state_nx;
      owner        <= owner_nx;
      rr_ptr       <= rr_ptr_nx;
      bytes_left   <= bytes_left_nx;
      o_Grant      <= grant_nx;
      o_Pop        <= pop_nx;
      o_RX_Byte    <= rx_byte_nx;
      o_RX_Valid   <= rx_valid_nx;
      o_Done       <= done_nx;
      o_M_TX_Byte  <= m_tx_byte_nx;
      o_M_TX_En    <= m_tx_en_nx;
      o_M_TX_Count <= m_tx_count_nx;
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: loopback SPI master model, requester models,
// and a round-robin reference that predicts grant order and per-grant traffic.
module tb_spi_master_arbiter;
  localparam int NUM_REQ = 2;
  localparam int MAXB    = 10;
  localparam int CW      = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    i_Req;
  logic [2*CW-1:0] i_Req_Count;
  logic [15:0]   i_Req_Byte;
  logic [1:0]    o_Grant, o_Pop, o_RX_Valid, o_Done;
  logic [7:0]    o_RX_Byte, o_M_TX_Byte;
  logic          o_M_TX_En;
  logic [CW-1:0] o_M_TX_Count;
  logic          m_ready   = 1'b1;
  logic          m_rx_en   = 1'b0;
  logic [7:0]    m_rx_byte = 8'h00;

  spi_master_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BYTES_PER_CS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .i_Req(i_Req), .i_Req_Count(i_Req_Count),
    .i_Req_Byte(i_Req_Byte), .o_Grant(o_Grant), .o_Pop(o_Pop),
    .o_RX_Byte(o_RX_Byte), .o_RX_Valid(o_RX_Valid), .o_Done(o_Done),
    .o_M_TX_Byte(o_M_TX_Byte), .o_M_TX_En(o_M_TX_En), .i_M_TX_Ready(m_ready),
    .o_M_TX_Count(o_M_TX_Count), .i_M_RX_Byte(m_rx_byte), .i_M_RX_En(m_rx_en)
  );

  always #5 clk = ~clk;

  // Requester side: a requester keeps i_Req high while it has transactions outstanding.
  logic [7:0]    tb_bytes [2][16];
  logic [CW-1:0] tb_cnt [2] = '{4'd0, 4'd0};
  logic [3:0]    pidx [2]   = '{4'd0, 4'd0};
  int            want [2]   = '{0, 0};
  int            done_n [2] = '{0, 0};

  assign i_Req_Count = {tb_cnt[1], tb_cnt[0]};
  assign i_Req_Byte  = {tb_bytes[1][pidx[1]], tb_bytes[0][pidx[0]]};
  assign i_Req       = {done_n[1] < want[1], done_n[0] < want[0]};

  // Per-grant log.
  int         g_owner [64], g_count [64], g_txen [64], g_pops [64];
  int         g_rxv [64], g_done [64], g_gcyc [64], g_dcyc [64];
  logic [7:0] g_mtx [64][16];
  logic [7:0] g_rx  [64][16];
  int         ntr = 0, cur = 0, cyc = 0;
  bit         have_cur = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] omask;
  int         bad_txen = 0, bad_route = 0, stray = 0, bad_onehot = 0;
  int         busy = 0, lat = 0;
  logic [7:0] m_data = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 0; m_ready = 1'b1; m_rx_en = 1'b0;
      pidx[0] = 4'd0; pidx[1] = 4'd0;
      prev_grant = 2'b00; have_cur = 1'b0;
    end else begin
      // loopback master: one byte in flight, returns what was sent
      if (o_M_TX_En && !m_ready) bad_txen++;
      m_rx_en = 1'b0;
      if (busy != 0) begin
        if (lat == 0) begin
          m_rx_en = 1'b1; m_rx_byte = m_data; busy = 0; m_ready = 1'b1;
        end else lat--;
      end else if (o_M_TX_En) begin
        busy = 1; m_ready = 1'b0; m_data = o_M_TX_Byte; lat = int'($urandom_range(0, 3));
      end

      if (o_Grant != 2'b00 && prev_grant == 2'b00 && ntr < 64) begin
        cur = ntr; ntr++;
        g_owner[cur] = o_Grant[1] ? 1 : 0;
        g_count[cur] = int'(o_M_TX_Count);
        g_txen[cur] = 0; g_pops[cur] = 0; g_rxv[cur] = 0; g_done[cur] = 0;
        g_gcyc[cur] = cyc; g_dcyc[cur] = 0;
        have_cur = 1'b1;
        if (!$onehot(o_Grant)) bad_onehot++;
      end
      prev_grant = o_Grant;

      if (have_cur) begin
        omask = 2'(1 << g_owner[cur]);
        if (o_M_TX_En) begin
          if (o_Grant == 2'b00) stray++;
          if (g_txen[cur] < 16) g_mtx[cur][g_txen[cur]] = o_M_TX_Byte;
          g_txen[cur]++;
        end
        if (o_Pop != 2'b00) begin
          if (o_Pop != omask || !o_M_TX_En) bad_route++;
          g_pops[cur]++;
        end
        if (o_RX_Valid != 2'b00) begin
          if (o_RX_Valid != omask) bad_route++;
          if (g_rxv[cur] < 16) g_rx[cur][g_rxv[cur]] = o_RX_Byte;
          g_rxv[cur]++;
        end
        if (o_Done != 2'b00) begin
          if (o_Done != omask) bad_route++;
          g_done[cur]++; g_dcyc[cur] = cyc;
        end
      end else if (o_M_TX_En || o_Pop != 2'b00 || o_RX_Valid != 2'b00 || o_Done != 2'b00) begin
        stray++;
      end

      for (int n = 0; n < 2; n++) begin
        if (o_Pop[n] && pidx[n] != 4'd15) pidx[n] = pidx[n] + 4'd1;
        if (o_Done[n]) begin pidx[n] = 4'd0; done_n[n]++; end
      end
    end
  end

  int n_cmp = 0, n_fail = 0;
  int mptr = 0;
  int exp_seq[$];
  int base = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {3'b000, o_Grant, o_Pop, o_RX_Valid, o_Done, o_M_TX_En,
              o_M_TX_Byte, o_RX_Byte, o_M_TX_Count}, 32'd0);
  endtask

  // Round-robin reference: pending counts per requester, pointer starts after last owner.
  function automatic void plan(input int k0, input int k1);
    int p[2];
    int o, idx;
    p[0] = k0; p[1] = k1;
    exp_seq.delete();
    while (p[0] + p[1] > 0) begin
      o = -1;
      for (int i = 0; i < 2; i++) begin
        idx = (mptr + i) % 2;
        if (o < 0 && p[idx] > 0) o = idx;
      end
      exp_seq.push_back(o);
      p[o]--;
      mptr = (o + 1) % 2;
    end
  endfunction

  task automatic launch(input int k0, input int k1);
    base = ntr;
    plan(k0, k1);
    want[0] += k0;
    want[1] += k1;
  endtask

  task automatic check_trans(input int t, input int o, input string tag);
    int k;
    k = (int'(tb_cnt[o]) > MAXB) ? MAXB : int'(tb_cnt[o]);
    chk({tag, "_owner"}, g_owner[t], o);
    chk({tag, "_count"}, g_count[t], k);
    chk({tag, "_txen"},  g_txen[t],  k);
    chk({tag, "_pops"},  g_pops[t],  k);
    chk({tag, "_rxv"},   g_rxv[t],   k);
    chk({tag, "_done"},  g_done[t],  1);
    for (int i = 0; i < k; i++) begin
      chk({tag, "_txbyte"}, g_mtx[t][i], tb_bytes[o][i]);
      chk({tag, "_rxbyte"}, g_rx[t][i],  tb_bytes[o][i]);
    end
  endtask

  task automatic finish_batch(input string tag);
    int budget, c;
    budget = 150 * exp_seq.size() + 20;
    c = 0;
    while ((done_n[0] < want[0] || done_n[1] < want[1]) && c < budget) begin
      step();
      c++;
    end
    chk({tag, "_timeout"}, 32'(done_n[0] >= want[0] && done_n[1] >= want[1]), 32'd1);
    step(); step();
    chk({tag, "_grants"}, ntr, base + exp_seq.size());
    foreach (exp_seq[i]) check_trans(base + i, exp_seq[i], tag);
  endtask

  task automatic rand_bytes();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 16; i++) tb_bytes[n][i] = 8'($urandom);
  endtask

  initial begin
    int c, aborted;
    rst_n = 1'b0;
    rand_bytes();
    repeat (3) step();
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    step();
    chk("idle_no_grant", o_Grant, 2'b00);

    // single requester, three bytes, grant one cycle after request
    tb_bytes[0][0] = 8'h11; tb_bytes[0][1] = 8'h22; tb_bytes[0][2] = 8'h33;
    tb_cnt[0] = 4'd3;
    launch(1, 0);
    step();
    chk("t1_grant_latency", o_Grant, 2'b01);
    finish_batch("t1");

    // simultaneous requests straight after reset: 0 then 1
    rst_n = 1'b0; step(); rst_n = 1'b1; mptr = 0; step();
    rand_bytes();
    tb_cnt[0] = 4'd2; tb_cnt[1] = 4'd2;
    launch(1, 1);
    finish_batch("t2");

    // both keep requesting: grants must alternate
    rand_bytes();
    tb_cnt[0] = 4'd1; tb_cnt[1] = 4'd2;
    launch(2, 2);
    finish_batch("t3");
    for (int i = 0; i < 4; i++) chk("t3_alternate", g_owner[base + i], i % 2);

    // zero-length transaction
    tb_cnt[1] = 4'd0;
    launch(0, 1);
    finish_batch("t4");
    chk("t4_done_within_3", 32'(g_dcyc[base] - g_gcyc[base] <= 3 && g_dcyc[base] > g_gcyc[base]), 32'd1);

    // count above the frame limit is clamped
    rand_bytes();
    tb_cnt[0] = 4'd15;
    launch(1, 0);
    finish_batch("t5");

    // reset in the middle of a transaction
    rand_bytes();
    tb_cnt[0] = 4'd4;
    launch(1, 0);
    c = 0;
    while (!(ntr > base && g_txen[base] >= 2) && c < 200) begin step(); c++; end
    chk("t6_second_byte_seen", 32'(ntr > base && g_txen[base] >= 2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_reset_outputs");
    aborted = base;
    repeat (3) step();
    chk_zero("t6_held_in_reset");
    rst_n = 1'b1;
    mptr = 0;
    base = ntr;
    plan(1, 0);
    finish_batch("t6_retry");
    chk("t6_aborted_no_done", g_done[aborted], 0);

    // randomized batches
    repeat (6) begin
      rand_bytes();
      tb_cnt[0] = CW'($urandom_range(0, 15));
      tb_cnt[1] = CW'($urandom_range(0, 15));
      launch(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      finish_batch("rnd");
    end

    chk("tx_en_while_busy", bad_txen, 0);
    chk("pulse_routing", bad_route, 0);
    chk("stray_traffic", stray, 0);
    chk("grant_onehot", bad_onehot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
